sc_game_controller: RTL

Sequencing controller for the 8x8 falling-piece playfield. It owns the moves of the point (falling piece) register bank: gravity drops, left/right shifts, undo, merge into the background bank and new-piece loading. It decides each move from the active-low collision flag of the collision detector, which compares the point and background banks row by row. It sits between the debounced button inputs and the point/background register banks, and also keeps the piece score and game-over status.

---
 rtl/sc_game_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sc_game_controller.sv
// Sequencing FSM for the 8x8 falling-piece playfield: gravity, shifts, undo, merge, load, score.
// Optional macro SC_GAMECTRL_SPEEDUP_EN shortens the gravity period as the score grows.
module sc_game_controller #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned TICK_WIDTH = 25
) (
  input  logic       SC_GAMECTRL_CLOCK_50,
  input  logic       SC_GAMECTRL_RESET_InLow,
  input  logic       SC_GAMECTRL_start_In,
  input  logic       SC_GAMECTRL_left_In,
  input  logic       SC_GAMECTRL_right_In,
  input  logic       SC_GAMECTRL_collision_InLow,
  output logic       SC_GAMECTRL_load_Out,
  output logic       SC_GAMECTRL_down_Out,
  output logic       SC_GAMECTRL_up_Out,
  output logic       SC_GAMECTRL_left_Out,
  output logic       SC_GAMECTRL_right_Out,
  output logic       SC_GAMECTRL_merge_Out,
  output logic       SC_GAMECTRL_gameOver_Out,
  output logic [7:0] SC_GAMECTRL_score_OutBUS,
  output logic [3:0] SC_GAMECTRL_state_OutBUS
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_CHKLOAD  = 4'd2,
    S_WAIT     = 4'd3,
    S_MOVE     = 4'd4,
    S_CHKMOVE  = 4'd5,
    S_UNDO     = 4'd6,
    S_MERGE    = 4'd7,
    S_GAMEOVER = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    MV_DOWN  = 2'd0,
    MV_LEFT  = 2'd1,
    MV_RIGHT = 2'd2
  } move_t;

  localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(TICK_DIV - 1);

  state_t                state_q, state_d;
  move_t                 move_q, move_d;
  logic                  tick_pend_q, tick_pend_d;
  logic                  left_pend_q, left_pend_d;
  logic                  right_pend_q, right_pend_d;
  logic [TICK_WIDTH-1:0] cnt_q, cnt_d, cnt_last;
  logic [7:0]            score_q, score_d;
  logic                  load_q, load_d, down_q, down_d, up_q, up_d;
  logic                  shl_q, shl_d, shr_q, shr_d, merge_q, merge_d, over_q, over_d;
  logic                  in_play, tick_evt, left_evt, right_evt;

  always_comb begin
    in_play   = (state_q != S_IDLE) && (state_q != S_GAMEOVER);
    tick_evt  = in_play && (cnt_q == cnt_last);
    left_evt  = in_play && SC_GAMECTRL_left_In;
    right_evt = in_play && SC_GAMECTRL_right_In;
    cnt_d     = '0;
    if (in_play && !tick_evt) cnt_d = cnt_q + 1'b1;
  end

`ifdef SC_GAMECTRL_SPEEDUP_EN
  logic [TICK_WIDTH-1:0] cnt_last_q, cnt_last_d;
  logic [1:0]            level;
  logic [31:0]           period_full;

  // The wrap point is only re-evaluated at a wrap, so a level change never cuts a period short.
  always_comb begin
    level       = (score_q[7:4] > 4'd3) ? 2'd3 : score_q[5:4];
    period_full = TICK_DIV >> level;
    cnt_last_d  = cnt_last_q;
    if (!in_play)      cnt_last_d = TICK_LAST;
    else if (tick_evt) cnt_last_d = TICK_WIDTH'(period_full - 32'd1);
  end

  always_ff @(posedge SC_GAMECTRL_CLOCK_50 or negedge SC_GAMECTRL_RESET_InLow) begin
    if (!SC_GAMECTRL_RESET_InLow) cnt_last_q <= TICK_LAST;
    else                          cnt_last_q <= cnt_last_d;
  end

  assign cnt_last = cnt_last_q;
`else
  assign cnt_last = TICK_LAST;
`endif

  always_comb begin
    state_d      = state_q;
    move_d       = move_q;
    score_d      = score_q;
    tick_pend_d  = tick_pend_q | tick_evt;
    left_pend_d  = left_pend_q | left_evt;
    right_pend_d = right_pend_q | right_evt;
    case (state_q)
      S_IDLE, S_GAMEOVER: begin
        if (SC_GAMECTRL_start_In) begin
          state_d = S_LOAD;
          score_d = 8'd0;
        end
      end
      S_LOAD:    state_d = S_CHKLOAD;
      S_CHKLOAD: state_d = SC_GAMECTRL_collision_InLow ? S_WAIT : S_GAMEOVER;
      S_WAIT: begin
        if (tick_pend_q) begin
          move_d  = MV_DOWN;
          state_d = S_MOVE;
        end else if (left_pend_q ^ right_pend_q) begin
          move_d  = left_pend_q ? MV_LEFT : MV_RIGHT;
          state_d = S_MOVE;
        end else if (left_pend_q && right_pend_q) begin
          left_pend_d  = left_evt;
          right_pend_d = right_evt;
        end
      end
      S_MOVE: begin
        // A fresh event in the serving cycle survives the clear.
        case (move_q)
          MV_LEFT:  left_pend_d  = left_evt;
          MV_RIGHT: right_pend_d = right_evt;
          default:  tick_pend_d  = tick_evt;
        endcase
        state_d = S_CHKMOVE;
      end
      S_CHKMOVE: state_d = SC_GAMECTRL_collision_InLow ? S_WAIT : S_UNDO;
      S_UNDO:    state_d = (move_q == MV_DOWN) ? S_MERGE : S_WAIT;
      S_MERGE: begin
        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_LOAD) begin
      tick_pend_d  = 1'b0;
      left_pend_d  = 1'b0;
      right_pend_d = 1'b0;
    end
  end

  // Command outputs are single-cycle strobes with no back-pressure; the register banks act
  // on the edge that ends each strobe, and the detector result is sampled one state later.
  always_comb begin
    load_d  = (state_d == S_LOAD);
    down_d  = (state_d == S_MOVE) && (move_d == MV_DOWN);
    up_d    = (state_d == S_UNDO) && (move_d == MV_DOWN);
    shl_d   = ((state_d == S_MOVE) && (move_d == MV_LEFT)) ||
              ((state_d == S_UNDO) && (move_d == MV_RIGHT));
    shr_d   = ((state_d == S_MOVE) && (move_d == MV_RIGHT)) ||
              ((state_d == S_UNDO) && (move_d == MV_LEFT));
    merge_d = (state_d == S_MERGE);
    over_d  = (state_d == S_GAMEOVER);
  end

  always_ff @(posedge SC_GAMECTRL_CLOCK_50 or negedge SC_GAMECTRL_RESET_InLow) begin
    if (!SC_GAMECTRL_RESET_InLow) begin
      state_q      <= S_IDLE;
      move_q       <= MV_DOWN;
      tick_pend_q  <= 1'b0;
      left_pend_q  <= 1'b0;
      right_pend_q <= 1'b0;
      cnt_q        <= '0;
      score_q      <= 8'd0;
      load_q       <= 1'b0;
      down_q       <= 1'b0;
      up_q         <= 1'b0;
      shl_q        <= 1'b0;
      shr_q        <= 1'b0;
      merge_q      <= 1'b0;
      over_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      move_q       <= move_d;
      tick_pend_q  <= tick_pend_d;
      left_pend_q  <= left_pend_d;
      right_pend_q <= right_pend_d;
      cnt_q        <= cnt_d;
      score_q      <= score_d;
      load_q       <= load_d;
      down_q       <= down_d;
      up_q         <= up_d;
      shl_q        <= shl_d;
      shr_q        <= shr_d;
      merge_q      <= merge_d;
      over_q       <= over_d;
    end
  end

  assign SC_GAMECTRL_load_Out     = load_q;
  assign SC_GAMECTRL_down_Out     = down_q;
  assign SC_GAMECTRL_up_Out       = up_q;
  assign SC_GAMECTRL_left_Out     = shl_q;
  assign SC_GAMECTRL_right_Out    = shr_q;
  assign SC_GAMECTRL_merge_Out    = merge_q;
  assign SC_GAMECTRL_gameOver_Out = over_q;
  assign SC_GAMECTRL_score_OutBUS = score_q;
  assign SC_GAMECTRL_state_OutBUS = state_q;

endmodule
